// File: rtl/tone_pkg.sv
// Shared tone definitions: period width common with the square-wave generator,
// detector state encoding and the saturated counter value.
package tone_pkg;
    localparam int TONE_WIDTH = 12;
    localparam int TONE_MAX   = (1 << TONE_WIDTH) - 1;

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE} tone_state_e;
endpackage

// File: rtl/tone_detector_if.sv
// Tone detector bus: wave/enable toward the detector, measurement and status back.
interface tone_detector_if
    import tone_pkg::*;
#(
    parameter int WIDTH = TONE_WIDTH
);
    logic             wave_in;
    logic             enable;
    logic [WIDTH-1:0] period_out;
    logic             valid;
    logic             locked;
    logic             no_tone;

    modport master (output wave_in, enable, input period_out, valid, locked, no_tone);
    modport slave  (input wave_in, enable, output period_out, valid, locked, no_tone);
endinterface

// File: rtl/sync_edge_det.sv
// Synchronizes the asynchronous wave input and flags every toggle (both polarities)
// as a one-cycle pulse.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_p
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            sync_d1 <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            sync_d1 <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_p = sync_q[SYNC_STAGES-1] ^ sync_d1;
endmodule

// File: rtl/tone_detector.sv
// Measures the toggle-to-toggle interval of a square wave and reports it in the
// generator's period encoding (interval minus one), with match/lock and no-tone status.
module tone_detector
    import tone_pkg::*;
#(
    parameter int WIDTH       = TONE_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int MATCH_TOL   = 1,
    parameter int LOCK_COUNT  = 2
) (
    input logic            clk,
    input logic            rst_n,
    tone_detector_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam int               MCW = $clog2(LOCK_COUNT + 1);

    tone_state_e      state;
    logic [WIDTH-1:0] cnt, prev, diff, period_out;
    logic [MCW-1:0]   match_cnt, mc_inc;
    logic             have_prev, valid, locked, no_tone, edge_p, is_match;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.wave_in),
        .edge_p(edge_p)
    );

    // prev is meaningless until one full interval has been measured in this run
    assign diff     = (cnt >= prev) ? cnt - prev : prev - cnt;
    assign is_match = have_prev && (diff <= WIDTH'(MATCH_TOL));
    assign mc_inc   = (match_cnt == MCW'(LOCK_COUNT)) ? match_cnt : match_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            prev       <= '0;
            have_prev  <= 1'b0;
            match_cnt  <= '0;
            period_out <= '0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            no_tone    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!bus.enable) begin
                state     <= IDLE;
                cnt       <= '0;
                match_cnt <= '0;
                have_prev <= 1'b0;
                locked    <= 1'b0;
                no_tone   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARMED;
                        cnt   <= '0;
                    end
                    ARMED: begin
                        if (edge_p) begin
                            state     <= MEASURE;
                            cnt       <= '0;
                            have_prev <= 1'b0;
                            match_cnt <= '0;
                        end else if (cnt == MAX) begin
                            no_tone <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    MEASURE: begin
                        // an edge on the saturating cycle still reports MAX
                        if (edge_p) begin
                            period_out <= cnt;
                            valid      <= 1'b1;
                            prev       <= cnt;
                            have_prev  <= 1'b1;
                            cnt        <= '0;
                            no_tone    <= 1'b0;
                            if (is_match) begin
                                match_cnt <= mc_inc;
                                if (mc_inc == MCW'(LOCK_COUNT)) locked <= 1'b1;
                            end else begin
                                match_cnt <= '0;
                                locked    <= 1'b0;
                            end
                        end else if (cnt == MAX) begin
                            state     <= ARMED;
                            no_tone   <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.period_out = period_out;
    assign bus.valid      = valid;
    assign bus.locked     = locked;
    assign bus.no_tone    = no_tone;
endmodule
